rv32_timer: RTL and testbench
=============================

Name: rv32_timer

Overview:
- Memory-mapped machine timer peripheral: the consumer of the execute stage's 64-bit `cycle_out` count.
- Exposes RISC-V mtime/mtimecmp on the data bus and raises the machine timer interrupt.
- mtime is derived as `cycle_in + offset`, so software can set mtime without touching the CSR cycle counter.

Parameters:
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (keeps the interrupt deasserted until software programs it).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cycle_in  input  64  free-running cycle count from the execute stage, +1 per clk
- address_in  input  32  byte address; only bits [3:2] are decoded
- sel_in  input  1  access request, held until ready_out
- read_in  input  1  1 = read, 0 = write (with write_mask_in)
- write_mask_in  input  4  byte-lane enables; bit n selects bits [8n+7:8n]
- write_value_in  input  32  write data
- read_value_out  output  32  read data, valid while ready_out=1
- ready_out  output  1  one-cycle access-complete strobe
- timer_interrupt_out  output  1  registered machine timer interrupt pending

Behaviour:
- Register map by address_in[3:2]:
  - 0 = mtime[31:0]
  - 1 = mtime[63:32] (shadow on read)
  - 2 = mtimecmp[31:0]
  - 3 = mtimecmp[63:32]
- mtime = cycle_in + offset, modulo 2^64. offset is a 64-bit register.
- Reset (reset=0, asynchronous): offset=0, mtimecmp=MTIMECMP_RESET, mtime_hi_shadow=0, read_value_out=0, ready_out=0, timer_interrupt_out=0, FSM=IDLE.
- FSM IDLE, sel_in=1 (access accepted at this edge):
  - Read: read_value_out <= selected word, where index 0 returns mtime[31:0] and also loads mtime_hi_shadow <= mtime[63:32]; index 1 returns mtime_hi_shadow; indices 2/3 return mtimecmp halves. Reads have no side effects beyond the shadow.
  - Write: new = selected 64-bit value with masked bytes of the addressed word replaced. For mtime, offset <= new - cycle_in, so mtime reads new+1 the following cycle, matching a counter that advanced. For mtimecmp, the register is updated directly.
  - Write with mask 0: no state change, still acknowledged.
  - read_value_out on a write: 0.
  - Then ready_out <= 1, go to RESP.
- FSM IDLE, sel_in=0: stay; ready_out <= 0.
- FSM RESP:
  - ready_out <= 0, read_value_out <= 0, go to IDLE.
  - sel_in is ignored during RESP; the master drops or re-raises sel_in after seeing ready.
  - Back-to-back accesses therefore complete every 2 cycles.
- Latency: ready_out is high exactly one cycle, the cycle after acceptance.
- Interrupt: every cycle, timer_interrupt_out <= (mtime >= mtimecmp), unsigned 64-bit compare using current-cycle values. It tracks a write one cycle after the write edge. It is level, not sticky; clearing is done by writing mtimecmp.
- mtime wraps 2^64-1 -> 0 naturally via the modular add. Once mtime wraps below mtimecmp, the interrupt deasserts.
- Reset mid-access: FSM returns to IDLE immediately and ready_out drops. A partially-performed write persists only if its edge preceded reset assertion.
- address_in bits other than [3:2] are don't-care; all four indices are valid (no bus error).

Test Plan:
- Reset released, cycle_in=100, read idx0 -> ready_out one cycle later, read_value_out=100 (value at acceptance edge), timer_interrupt_out=0 throughout.
- cycle_in=0x0000_0001_FFFF_FFFF, read idx0 then idx1 -> 0xFFFF_FFFF then 1 (shadow), even though cycle_in has carried to 0x2_0000_0000+ by the second read.
- Write idx2=50, idx3=0, mask 4'hF, while cycle_in=40 -> interrupt rises the cycle after mtime reaches 50 (cycle_in=50); writing idx3=1 drops it the next cycle.
- Write idx0=0x1000, mask 4'hF, at cycle_in=7 -> next-cycle idx0 read returns 0x1001 + elapsed cycles; mtime[63:32] unchanged.
- Write idx2 with mask 4'b0010, data 0x0000_AB00, from mtimecmp reset value -> mtimecmp[31:0]=0xFFFF_ABFF, other bytes unchanged.
- Assert reset during RESP of a read -> ready_out=0 and read_value_out=0 immediately; mtimecmp=MTIMECMP_RESET and offset=0 after release.

Source files
------------

// File: rtl/rv32_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_timer
//  Description : Memory-mapped RISC-V machine timer. mtime is formed as the
//                execute-stage cycle count plus a software-adjustable offset;
//                mtimecmp is a plain register. Raises a registered, level
//                machine-timer interrupt while mtime >= mtimecmp.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32_timer #(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] cycle_in,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        timer_interrupt_out
);

    // Register indices decoded from address_in[3:2]
    localparam logic [1:0] c_IDX_MTIME_LO = 2'd0;
    localparam logic [1:0] c_IDX_MTIME_HI = 2'd1;
    localparam logic [1:0] c_IDX_CMP_LO   = 2'd2;
    localparam logic [1:0] c_IDX_CMP_HI   = 2'd3;

    // Access FSM states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]  r_state;
    logic [63:0] r_offset;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_mtime_hi_shadow;
    logic [31:0] r_read_value;
    logic        r_ready;
    logic        r_irq;

    logic [63:0] w_mtime;
    logic [1:0]  w_idx;
    logic [31:0] w_lane_mask;
    logic [31:0] w_old_word;
    logic [31:0] w_new_word;
    logic [31:0] w_read_word;
    logic [63:0] w_new_mtime;
    logic [63:0] w_new_cmp;
    logic        w_write_en;
    logic        w_unused_addr;

    // Only address bits [3:2] select a register; the rest are don't-care.
    assign w_unused_addr = ^{address_in[31:4], address_in[1:0]};

    assign w_mtime    = cycle_in + r_offset;
    assign w_idx      = address_in[3:2];
    assign w_write_en = |write_mask_in;

    // Expand the 4 byte enables into a 32-bit bit mask
    genvar g;
    generate
        for (g = 0; g < 4; g = g + 1) begin : g_lane
            assign w_lane_mask[8*g +: 8] = {8{write_mask_in[g]}};
        end
    endgenerate

    // Current contents of the addressed word, used as the merge base for writes
    always_comb begin
        w_old_word = 32'd0;
        case (w_idx)
            c_IDX_MTIME_LO: w_old_word = w_mtime[31:0];
            c_IDX_MTIME_HI: w_old_word = w_mtime[63:32];
            c_IDX_CMP_LO:   w_old_word = r_mtimecmp[31:0];
            c_IDX_CMP_HI:   w_old_word = r_mtimecmp[63:32];
            default:        w_old_word = 32'd0;
        endcase
    end

    assign w_new_word = (w_old_word & ~w_lane_mask) | (write_value_in & w_lane_mask);

    // Full 64-bit values after splicing the merged word into its half
    assign w_new_mtime = w_idx[0] ? {w_new_word, w_mtime[31:0]}
                                  : {w_mtime[63:32], w_new_word};
    assign w_new_cmp   = w_idx[0] ? {w_new_word, r_mtimecmp[31:0]}
                                  : {r_mtimecmp[63:32], w_new_word};

    // Read data mux; the high half of mtime comes from the shadow captured
    // by the preceding low-half read so a 64-bit read is carry-consistent.
    always_comb begin
        w_read_word = 32'd0;
        case (w_idx)
            c_IDX_MTIME_LO: w_read_word = w_mtime[31:0];
            c_IDX_MTIME_HI: w_read_word = r_mtime_hi_shadow;
            c_IDX_CMP_LO:   w_read_word = r_mtimecmp[31:0];
            c_IDX_CMP_HI:   w_read_word = r_mtimecmp[63:32];
            default:        w_read_word = 32'd0;
        endcase
    end

    // Bus access FSM: accept in IDLE, acknowledge for one cycle in RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_offset          <= 64'd0;
            r_mtimecmp        <= MTIMECMP_RESET;
            r_mtime_hi_shadow <= 32'd0;
            r_read_value      <= 32'd0;
            r_ready           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sel_in) begin
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                        if (read_in) begin
                            r_read_value <= w_read_word;
                            if (w_idx == c_IDX_MTIME_LO) begin
                                r_mtime_hi_shadow <= w_mtime[63:32];
                            end
                        end else begin
                            r_read_value <= 32'd0;
                            if (w_write_en) begin
                                if (w_idx[1]) begin
                                    r_mtimecmp <= w_new_cmp;
                                end else begin
                                    // Offset chosen so mtime equals the written
                                    // value at this edge and keeps counting.
                                    r_offset <= w_new_mtime - cycle_in;
                                end
                            end
                        end
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_ready      <= 1'b0;
                    r_read_value <= 32'd0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ready      <= 1'b0;
                    r_read_value <= 32'd0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Level interrupt: unsigned compare of this cycle's mtime and mtimecmp
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_mtime >= r_mtimecmp);
        end
    end

    assign read_value_out      = r_read_value;
    assign ready_out           = r_ready;
    assign timer_interrupt_out = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_rv32_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_timer
//  Description : Directed self-checking bench for rv32_timer. The stimulus
//                block owns cycle_in and advances it by one per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32_timer;

    logic        clk;
    logic        reset;
    logic [63:0] cycle_in;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        timer_interrupt_out;

    int total;
    int bad;

    rv32_timer #(
        .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cycle_in           (cycle_in),
        .address_in         (address_in),
        .sel_in             (sel_in),
        .read_in            (read_in),
        .write_mask_in      (write_mask_in),
        .write_value_in     (write_value_in),
        .read_value_out     (read_value_out),
        .ready_out          (ready_out),
        .timer_interrupt_out(timer_interrupt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: outputs settle 1ns after the edge, then the cycle count advances
    task automatic tick();
        @(posedge clk);
        #1;
        cycle_in = cycle_in + 64'd1;
    endtask

    task automatic do_read(input logic [1:0] idx, output logic [31:0] data);
        sel_in     = 1'b1;
        read_in    = 1'b1;
        address_in = {28'h000_0000, idx, 2'b00};
        tick();
        sel_in = 1'b0;
        check("rd_ready_hi", {63'd0, ready_out}, 64'd1);
        data = read_value_out;
        tick();
        check("rd_ready_lo", {63'd0, ready_out}, 64'd0);
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [3:0] mask, input logic [31:0] val);
        sel_in         = 1'b1;
        read_in        = 1'b0;
        address_in     = {28'hABC_DEF0, idx, 2'b11};
        write_mask_in  = mask;
        write_value_in = val;
        tick();
        sel_in = 1'b0;
        check("wr_ready_hi", {63'd0, ready_out}, 64'd1);
        check("wr_rdata_zero", {32'd0, read_value_out}, 64'd0);
        tick();
        check("wr_ready_lo", {63'd0, ready_out}, 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [63:0] c;
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        cycle_in       = 64'd0;
        address_in     = 32'd0;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        write_mask_in  = 4'h0;
        write_value_in = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_ready", {63'd0, ready_out}, 64'd0);
        check("rst_rdata", {32'd0, read_value_out}, 64'd0);
        check("rst_irq", {63'd0, timer_interrupt_out}, 64'd0);
        reset    = 1'b1;
        cycle_in = 64'd100;

        // Read mtime low at cycle 100
        do_read(2'd0, d);
        check("rd_mtime_100", {32'd0, d}, 64'd100);
        check("irq_idle_0", {63'd0, timer_interrupt_out}, 64'd0);

        // Shadowed high read across a low-word carry
        cycle_in = 64'h0000_0001_FFFF_FFFF;
        do_read(2'd0, d);
        check("rd_lo_carry", {32'd0, d}, 64'h0000_0000_FFFF_FFFF);
        do_read(2'd1, d);
        check("rd_hi_shadow", {32'd0, d}, 64'd1);

        // mtimecmp = 50, interrupt rises after mtime reaches 50
        cycle_in = 64'd40;
        do_write(2'd2, 4'hF, 32'd50);
        do_write(2'd3, 4'hF, 32'd0);
        while (cycle_in < 64'd52) begin
            c = cycle_in;
            tick();
            check("irq_cmp50", {63'd0, timer_interrupt_out}, {63'd0, (c >= 64'd50)});
        end
        do_write(2'd3, 4'hF, 32'd1);
        check("irq_clear_hi", {63'd0, timer_interrupt_out}, 64'd0);

        // Write mtime low at cycle 7, then read back two cycles later
        cycle_in = 64'd7;
        do_write(2'd0, 4'hF, 32'h0000_1000);
        do_read(2'd0, d);
        check("rd_mtime_written", {32'd0, d}, 64'h0000_1002);
        do_read(2'd1, d);
        check("rd_mtime_hi_kept", {32'd0, d}, 64'd0);

        // Byte-masked write of mtime high: mtime becomes 0x5_0000_1006 at cycle 13
        do_write(2'd1, 4'b0001, 32'hFFFF_FF05);
        check("irq_after_hi_wr", {63'd0, timer_interrupt_out}, 64'd1);
        do_read(2'd0, d);
        check("rd_lo_after_hi_wr", {32'd0, d}, 64'h0000_1008);
        do_read(2'd1, d);
        check("rd_hi_after_hi_wr", {32'd0, d}, 64'd5);

        // Reset during RESP of a read
        sel_in     = 1'b1;
        read_in    = 1'b1;
        address_in = 32'h0000_0008;
        tick();
        sel_in = 1'b0;
        check("pre_rst_ready", {63'd0, ready_out}, 64'd1);
        check("pre_rst_rdata", {32'd0, read_value_out}, 64'd50);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, ready_out}, 64'd0);
        check("mid_rst_rdata", {32'd0, read_value_out}, 64'd0);
        check("mid_rst_irq", {63'd0, timer_interrupt_out}, 64'd0);
        tick();
        reset    = 1'b1;
        cycle_in = 64'd300;
        do_read(2'd2, d);
        check("rst_cmp_lo", {32'd0, d}, 64'hFFFF_FFFF);
        do_read(2'd3, d);
        check("rst_cmp_hi", {32'd0, d}, 64'hFFFF_FFFF);
        do_read(2'd0, d);
        check("rst_offset_zero", {32'd0, d}, 64'd304);

        // Byte-lane merge into mtimecmp low
        do_write(2'd2, 4'b0010, 32'h0000_AB00);
        do_read(2'd2, d);
        check("cmp_lane1", {32'd0, d}, 64'hFFFF_ABFF);
        do_read(2'd3, d);
        check("cmp_hi_untouched", {32'd0, d}, 64'hFFFF_FFFF);

        // Mask 0 write: acknowledged, no effect
        do_write(2'd3, 4'h0, 32'h0000_0000);
        do_read(2'd3, d);
        check("mask0_no_change", {32'd0, d}, 64'hFFFF_FFFF);

        // Wrap: mtimecmp = 2^64-8, mtime runs past 2^64-1 to small values
        cycle_in = 64'hFFFF_FFFF_FFFF_FFF0;
        do_write(2'd2, 4'hF, 32'hFFFF_FFF8);
        for (int i = 0; i < 20; i++) begin
            c = cycle_in;
            tick();
            check("irq_wrap", {63'd0, timer_interrupt_out},
                  {63'd0, (c >= 64'hFFFF_FFFF_FFFF_FFF8)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
